draw_scheduler: RTL and testbench

- Per-frame sequencer for the drawing pipeline.
- On each frame request it performs four steps in order:
  - clears the back buffer via fill_drawer;
  - runs logic_placeholder, which drives line_drawer;
  - waits for vertical blanking;
  - pulses frame_buffer swap.
- Owns the single frame_buffer write port: a state-selected mux between the fill_drawer and line_drawer write ports replaces the ad-hoc OR of the two.

---
 rtl/draw_scheduler_if.sv | 39 +++
 rtl/draw_scheduler.sv | 170 +++++++++++++++++
 tb/tb_draw_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_scheduler_if.sv
// Drawing-pipeline handshake and write-port bundle between draw_scheduler
// and its sub-blocks (fill_drawer, logic_placeholder/line_drawer, frame_buffer).
//   fill_start/fill_ready     start pulse / idle flag of fill_drawer
//   logic_start/logic_ready   start pulse / idle flag of logic_placeholder
//   fill_we/addr/data         fill_drawer write port
//   line_we/addr/data         line_drawer write port
//   fb_we/addr/data           muxed frame_buffer write port
// master = scheduler side, slave = drawer/frame_buffer side.
interface draw_scheduler_if #(
    parameter int ADDR_W = 19
);
    logic              fill_start;
    logic              fill_ready;
    logic              logic_start;
    logic              logic_ready;
    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_data;
    logic              line_we;
    logic [ADDR_W-1:0] line_addr;
    logic              line_data;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_data;

    modport master (
        output fill_start, logic_start, fb_we, fb_addr, fb_data,
        input  fill_ready, logic_ready,
        input  fill_we, fill_addr, fill_data,
        input  line_we, line_addr, line_data
    );

    modport slave (
        input  fill_start, logic_start, fb_we, fb_addr, fb_data,
        output fill_ready, logic_ready,
        output fill_we, fill_addr, fill_data,
        output line_we, line_addr, line_data
    );
endinterface

// File: rtl/draw_scheduler.sv
// Per-frame sequencer: clear back buffer (fill_drawer), run logic_placeholder
// (drives line_drawer), wait for vblank, pulse swap. Owns the single
// frame_buffer write port through a state-selected mux.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   frame_req         one-cycle frame request (one request can be queued)
//   vblank            level, high during vertical blanking
//   bus               draw_scheduler_if.master (drawer handshakes, write ports)
//   swap, frame_done  one-cycle pulses at end of frame
//   busy              high whenever not IDLE
//   frame_count       completed frames, wraps
//   error             sticky wait-stage timeout flag
// Optional: define DRAW_TIMEOUT_EN to bound every wait stage to
// TIMEOUT_CYCLES cycles; otherwise error is constant 0.
module draw_scheduler #(
    parameter int ADDR_W         = 19,
    parameter int COUNT_W        = 16,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_req,
    input  logic               vblank,
    draw_scheduler_if.master   bus,
    output logic               swap,
    output logic               busy,
    output logic               frame_done,
    output logic [COUNT_W-1:0] frame_count,
    output logic               error
);
    typedef enum logic [3:0] {
        IDLE, FILL_GO, FILL_GUARD, FILL_WAIT,
        LOGIC_GO, LOGIC_GUARD, LOGIC_WAIT, VBL_WAIT, SWAP
    } state_t;

    state_t state;
    logic   pending;
    logic   wait_exit;
    logic   tmo_hit;

    // Exit condition of whichever wait stage is active.
    always_comb begin
        wait_exit = 1'b0;
        case (state)
            FILL_WAIT:  wait_exit = bus.fill_ready;
            LOGIC_WAIT: wait_exit = bus.logic_ready;
            VBL_WAIT:   wait_exit = vblank;
            default:    wait_exit = 1'b0;
        endcase
    end

`ifdef DRAW_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             in_wait;

    assign in_wait = (state == FILL_WAIT) || (state == LOGIC_WAIT) || (state == VBL_WAIT);

    // Zero outside wait stages and on a wait exit, so every wait stage is
    // entered with a fresh count (LOGIC_WAIT -> VBL_WAIT included).
    always_ff @(posedge clk) begin
        if (!rst_n || !in_wait || wait_exit) tmo_cnt <= '0;
        else                                 tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = in_wait && !wait_exit && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            pending         <= 1'b0;
            bus.fill_start  <= 1'b0;
            bus.logic_start <= 1'b0;
            swap            <= 1'b0;
            frame_done      <= 1'b0;
            busy            <= 1'b0;
            frame_count     <= '0;
            error           <= 1'b0;
        end else begin
            bus.fill_start  <= 1'b0;
            bus.logic_start <= 1'b0;
            swap            <= 1'b0;
            frame_done      <= 1'b0;
            // Single-entry queue: extra requests while pending are dropped.
            if (frame_req && state != IDLE) pending <= 1'b1;
            case (state)
                IDLE: begin
                    // Both drawers must be idle: they are not reset by us and
                    // may still be running after a mid-frame reset.
                    if ((frame_req || pending) && bus.fill_ready && bus.logic_ready) begin
                        state          <= FILL_GO;
                        bus.fill_start <= 1'b1;
                        busy           <= 1'b1;
                        pending        <= 1'b0;
                        error          <= 1'b0;
                    end else if (frame_req) begin
                        pending <= 1'b1;   // hold the request until drawers are idle
                    end
                end
                FILL_GO:    state <= FILL_GUARD;
                // Drawer drops ready one cycle after start; skip that cycle.
                FILL_GUARD: state <= FILL_WAIT;
                FILL_WAIT: begin
                    if (wait_exit) begin
                        state           <= LOGIC_GO;
                        bus.logic_start <= 1'b1;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                LOGIC_GO:    state <= LOGIC_GUARD;
                LOGIC_GUARD: state <= LOGIC_WAIT;
                LOGIC_WAIT: begin
                    if (wait_exit) begin
                        state <= VBL_WAIT;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                VBL_WAIT: begin
                    if (wait_exit) begin
                        state       <= SWAP;
                        swap        <= 1'b1;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 1'b1;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                SWAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Write-port ownership follows the phase; stray writes are dropped.
    always_comb begin
        bus.fb_we   = 1'b0;
        bus.fb_addr = {ADDR_W{1'b0}};
        bus.fb_data = 1'b0;
        case (state)
            FILL_GO, FILL_GUARD, FILL_WAIT: begin
                bus.fb_we   = bus.fill_we;
                bus.fb_addr = bus.fill_addr;
                bus.fb_data = bus.fill_data;
            end
            LOGIC_GO, LOGIC_GUARD, LOGIC_WAIT: begin
                bus.fb_we   = bus.line_we;
                bus.fb_addr = bus.line_addr;
                bus.fb_data = bus.line_data;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;
    localparam int ADDR_W  = 19;
    localparam int COUNT_W = 16;
    localparam int DRAW_LAT = 10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               frame_req;
    logic               vblank;
    logic               swap, busy, frame_done, error;
    logic [COUNT_W-1:0] frame_count;
    logic               logic_hold;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int exp_count = 0;
    int sb_e;

    draw_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    draw_scheduler #(.ADDR_W(ADDR_W), .COUNT_W(COUNT_W), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .vblank(vblank), .bus(bus),
        .swap(swap), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count), .error(error)
    );

    always #5 clk = ~clk;

    // Drawer models: ready drops the cycle after start and returns DRAW_LAT
    // cycles later. Not reset by rst_n, like the real sub-blocks.
    logic fill_rdy_q  = 1'b1;
    logic logic_rdy_q = 1'b1;
    int   fill_cnt    = 0;
    int   logic_cnt   = 0;

    always @(posedge clk) begin
        if (bus.fill_start) begin
            fill_rdy_q <= 1'b0; fill_cnt <= DRAW_LAT;
        end else if (!fill_rdy_q) begin
            if (fill_cnt == 1) fill_rdy_q <= 1'b1;
            fill_cnt <= fill_cnt - 1;
        end
        if (bus.logic_start) begin
            logic_rdy_q <= 1'b0; logic_cnt <= DRAW_LAT;
        end else if (!logic_rdy_q) begin
            if (logic_cnt == 1) logic_rdy_q <= 1'b1;
            logic_cnt <= logic_cnt - 1;
        end
    end

    assign bus.fill_ready  = fill_rdy_q;
    assign bus.logic_ready = logic_rdy_q & ~logic_hold;
    // Both drawers write concurrently all the time; the mux must pick one.
    assign bus.fill_we   = 1'b1;
    assign bus.fill_addr = 19'h12345;
    assign bus.fill_data = 1'b1;
    assign bus.line_we   = 1'b1;
    assign bus.line_addr = 19'h00100;
    assign bus.line_data = 1'b0;

    // Event monitor and scoreboard pop on every swap.
    int cyc = 0, n_fill = 0, n_logic = 0, t_fill = 0, t_logic = 0, t_swap = 0;
    always @(negedge clk) begin
        cyc++;
        if (bus.fill_start)  begin n_fill++;  t_fill  = cyc; end
        if (bus.logic_start) begin n_logic++; t_logic = cyc; end
        if (swap) begin
            t_swap = cyc;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL swap_unexpected: got swap with frame_count=%0d, expected no swap", frame_count);
            end else begin
                sb_e = exp_q.pop_front();
                if (frame_count !== COUNT_W'(sb_e) || frame_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL swap_scoreboard: frame_count=%0d frame_done=%0b, expected %0d/1",
                             frame_count, frame_done, sb_e);
                end
            end
        end
    end

    task automatic pulse_req();
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
    endtask

    task automatic expect_frame();
        exp_count++;
        exp_q.push_back(exp_count);
    endtask

    task automatic wait_fill_start(input string name);
        int k = 0;
        while (!bus.fill_start && k < 40) begin @(negedge clk); k++; end
        n_tests++;
        if (bus.fill_start !== 1'b1) begin
            n_fail++; $display("FAIL %s: fill_start=%0b, expected 1 within 40 cycles", name, bus.fill_start);
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 200) begin @(negedge clk); k++; end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL %s: busy=%0b, expected 0 within 200 cycles", name, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_req = 1'b0; vblank = 1'b0; logic_hold = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.fill_start, bus.logic_start, swap, frame_done, error, bus.fb_we, bus.fb_data} !== 7'b0 ||
            bus.fb_addr !== '0 || frame_count !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: fs=%0b ls=%0b swap=%0b fd=%0b err=%0b we=%0b addr=%h cnt=%0d, expected all 0",
                     bus.fill_start, bus.logic_start, swap, frame_done, error, bus.fb_we, bus.fb_addr, frame_count);
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: busy=%0b, expected 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        vblank = 1'b1; n_fill = 0; n_logic = 0;
        expect_frame();
        pulse_req();
        wait_fill_start("single_start");
        @(negedge clk);
        wait_idle("single_idle");
        n_tests++;
        if (n_fill !== 1 || n_logic !== 1) begin
            n_fail++; $display("FAIL single_pulses: fill=%0d logic=%0d, expected 1/1", n_fill, n_logic);
        end
        // FILL_GO+GUARD+10 wait cycles, then LOGIC likewise, VBL_WAIT, SWAP.
        n_tests++;
        if (t_logic - t_fill !== 12) begin
            n_fail++; $display("FAIL single_order: logic_start-fill_start=%0d, expected 12", t_logic - t_fill);
        end
        n_tests++;
        if (t_swap - t_logic !== 13) begin
            n_fail++; $display("FAIL single_swap_time: swap-logic_start=%0d, expected 13", t_swap - t_logic);
        end
        n_tests++;
        if (frame_count !== COUNT_W'(exp_count)) begin
            n_fail++; $display("FAIL single_count: frame_count=%0d, expected %0d", frame_count, exp_count);
        end
    endtask

    task automatic test_write_ownership();
        int bad;
        vblank = 1'b0;
        expect_frame();
        pulse_req();
        wait_fill_start("own_start");
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.fb_we !== 1'b1 || bus.fb_addr !== 19'h12345 || bus.fb_data !== 1'b1) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL own_fill: %0d bad cycles, expected fb_addr=12345 we=1", bad); end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.fb_we !== 1'b1 || bus.fb_addr !== 19'h00100 || bus.fb_data !== 1'b0) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL own_line: %0d bad cycles, expected fb_addr=00100 we=1", bad); end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.fb_we !== 1'b0 || bus.fb_addr !== '0 || busy !== 1'b1) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL own_vbl: %0d bad cycles, expected fb_we=0 addr=0 while busy", bad); end
        vblank = 1'b1;
        wait_idle("own_idle");
        n_tests++;
        if (bus.fb_we !== 1'b0 || bus.fb_addr !== '0) begin
            n_fail++; $display("FAIL own_idle_we: fb_we=%0b fb_addr=%h, expected 0/0", bus.fb_we, bus.fb_addr);
        end
    endtask

    task automatic test_back_to_back();
        vblank = 1'b1;
        expect_frame();
        pulse_req();
        wait_fill_start("queue_start");
        expect_frame();   // first extra request is queued, the other two dropped
        for (int i = 0; i < 3; i++) begin
            pulse_req();
            repeat (2) @(negedge clk);
        end
        repeat (150) @(negedge clk);
        n_tests++;
        if (frame_count !== COUNT_W'(exp_count) || busy !== 1'b0) begin
            n_fail++; $display("FAIL queue_count: frame_count=%0d busy=%0b, expected %0d/0", frame_count, busy, exp_count);
        end
    endtask

    task automatic test_vblank_wait();
        int k = 0;
        int bad = 0;
        vblank = 1'b0;
`ifndef DRAW_TIMEOUT_EN
        expect_frame();
`endif
        pulse_req();
        while (!bus.logic_start && k < 40) begin @(negedge clk); k++; end
        repeat (12) @(negedge clk);
        for (int i = 0; i < 500; i++) begin
            if (swap !== 1'b0) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL vbl_hold: swap seen %0d times, expected 0", bad); end
`ifdef DRAW_TIMEOUT_EN
        n_tests++;
        if (error !== 1'b1 || busy !== 1'b0 || frame_count !== COUNT_W'(exp_count)) begin
            n_fail++; $display("FAIL vbl_timeout: error=%0b busy=%0b cnt=%0d, expected 1/0/%0d",
                               error, busy, frame_count, exp_count);
        end
        vblank = 1'b1;
`else
        vblank = 1'b1;
        @(negedge clk);
        n_tests++;
        if (swap !== 1'b1 || error !== 1'b0) begin
            n_fail++; $display("FAIL vbl_release: swap=%0b error=%0b, expected 1/0", swap, error);
        end
        wait_idle("vbl_idle");
`endif
    endtask

    task automatic test_reset_mid_frame();
        int k = 0;
        int bad = 0;
        vblank = 1'b1;
        pulse_req();
        while (!bus.logic_start && k < 40) begin @(negedge clk); k++; end
        logic_hold = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        n_tests++;
        if (busy !== 1'b0 || frame_count !== '0 || error !== 1'b0) begin
            n_fail++; $display("FAIL midreset_idle: busy=%0b cnt=%0d err=%0b, expected 0/0/0", busy, frame_count, error);
        end
        pulse_req();
        for (int i = 0; i < 20; i++) begin
            if (bus.fill_start !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL midreset_gate: started %0d cycles early, expected held", bad); end
        expect_frame();
        logic_hold = 1'b0;
        wait_fill_start("midreset_restart");
        @(negedge clk);
        wait_idle("midreset_idle2");
        n_tests++;
        if (frame_count !== COUNT_W'(exp_count)) begin
            n_fail++; $display("FAIL midreset_count: frame_count=%0d, expected %0d", frame_count, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_write_ownership();
        test_back_to_back();
        test_vblank_wait();
        test_reset_mid_frame();
        begin
            int k = 0;
            while (exp_q.size() != 0 && k < 200) begin @(negedge clk); k++; end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d frames outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end
endmodule
